// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider, signed or unsigned per operation.
// Every operation takes the same number of cycles: one quotient bit per cycle, then a two-cycle
// sign-correction step. Divide-by-zero and signed overflow produce defined results.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while ready=1
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   flush        synchronous abort of an operation in flight; blocks start while idle
//   dividend     dividend, captured on the accepting edge
//   divisor      divisor, captured on the accepting edge
//   ready        idle, a start can be accepted
//   busy         operation in flight (~ready)
//   valid        one-cycle pulse, quotient/remainder/div_by_zero are new
//   quotient     quotient truncated toward zero, held until the next valid
//   remainder    remainder with the sign of the dividend, held until the next valid
//   div_by_zero  divisor was zero for the presented result
module seq_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] prem_q;      // partial remainder, always below the divisor
    logic [WIDTH-1:0] dvd_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;       // divisor magnitude
    logic [WIDTH-1:0] orig_q;      // untouched dividend, returned on divide-by-zero
    logic             sgn_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic             fix_ph_q;
    logic [WIDTH-1:0] fix_quo_q;
    logic [WIDTH-1:0] fix_rem_q;
    logic             valid_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_out_q;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes; only negative signed operands are negated.
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_abs = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

    // One restoring step: the shifted remainder is WIDTH+1 bits, so the subtractor's top bit is the borrow.
    assign shifted = {prem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    // Sign correction; divide-by-zero overrides the magnitude result.
    assign quo_fix = dz_q ? '1 :
                     ((sgn_q & neg_quo_q) ? (~dvd_q + WIDTH'(1)) : dvd_q);
    assign rem_fix = dz_q ? orig_q :
                     ((sgn_q & neg_rem_q) ? (~prem_q + WIDTH'(1)) : prem_q);

    // Control and datapath; flush wins over start and over completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            orig_q    <= '0;
            sgn_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            fix_ph_q  <= 1'b0;
            fix_quo_q <= '0;
            fix_rem_q <= '0;
            valid_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_out_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        dvd_q     <= dvd_abs;
                        dvs_q     <= dvs_abs;
                        orig_q    <= dividend;
                        sgn_q     <= is_signed;
                        neg_quo_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_q <= dividend[WIDTH-1];
                        dz_q      <= (divisor == '0);
                        prem_q    <= '0;
                        cnt_q     <= '0;
                        fix_ph_q  <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        prem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        dvd_q  <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    // First cycle registers the corrected values so the negation adders stay off the output path.
                    if (flush) begin
                        fix_ph_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (!fix_ph_q) begin
                        fix_quo_q <= quo_fix;
                        fix_rem_q <= rem_fix;
                        fix_ph_q  <= 1'b1;
                    end else begin
                        quo_q    <= fix_quo_q;
                        rem_q    <= fix_rem_q;
                        dz_out_q <= dz_q;
                        valid_q  <= 1'b1;
                        fix_ph_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign busy        = ~ready;
    assign valid       = valid_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_out_q;

endmodule
